// File: rtl/vec_length_pkg.sv
// Shared fixed-point types, constants and FSM states for the vec_length datapath.
// Optional feature macro used by vec_length: VEC_LENGTH_SAT_EN.
package definitions_pack;
  localparam int _WIDTH = 32;
  localparam int BI = 16;
  typedef logic signed [_WIDTH-1:0] fixed;
endpackage

package math_pack;
  import definitions_pack::*;

  localparam int FB = _WIDTH - BI;
  localparam logic [_WIDTH-1:0] SAT_LIMIT = {1'b0, {(_WIDTH-1){1'b1}}};

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SQ_X      = 3'd1,
    SQ_Y      = 3'd2,
    SQ_Z      = 3'd3,
    SQRT_REQ  = 3'd4,
    SQRT_WAIT = 3'd5,
    DONE      = 3'd6
  } vl_state_t;

  // The most negative input maps to 2^(_WIDTH-1), which still fits unsigned.
  function automatic logic [_WIDTH-1:0] magnitude(input fixed c);
    logic [_WIDTH-1:0] u;
    u = c;
    return c[_WIDTH-1] ? (~u + _WIDTH'(1)) : u;
  endfunction
endpackage

// File: rtl/vec_length_if.sv
// Request/result and square-root handshake bundle for vec_length.
interface vec_length_if;
  import definitions_pack::*;

  logic in_valid;
  logic in_ready;
  fixed x;
  fixed y;
  fixed z;
  logic out_valid;
  logic out_ready;
  fixed len;
  logic ovf;
  logic sqrt_start;
  fixed sqrt_a;
  fixed sqrt_b;
  logic sqrt_ready;

  modport slave (
    input  in_valid, x, y, z, out_ready, sqrt_b, sqrt_ready,
    output in_ready, out_valid, len, ovf, sqrt_start, sqrt_a
  );

  modport master (
    output in_valid, x, y, z, out_ready, sqrt_b, sqrt_ready,
    input  in_ready, out_valid, len, ovf, sqrt_start, sqrt_a
  );
endinterface

// File: rtl/vec_length_fx_sq_iter.sv
// Iterative unsigned shift-add squarer retiring STEP multiplier bits per cycle (STEP in 1, 2, 4).
// product is combinational and holds the full square in the cycle done is high.
module fx_sq_iter
  import definitions_pack::*;
#(
  parameter int STEP = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [_WIDTH-1:0]     operand,
  output logic                  busy,
  output logic                  done,
  output logic [2*_WIDTH-1:0]   product
);
  localparam int N  = _WIDTH / STEP;
  localparam int CW = $clog2(N);

  logic [2*_WIDTH-1:0] acc_q;
  logic [2*_WIDTH-1:0] mcand_q;
  logic [_WIDTH-1:0]   mplier_q;
  logic [CW-1:0]       step_q;
  logic                busy_q;

  logic                load;
  logic [2*_WIDTH-1:0] cur_acc;
  logic [2*_WIDTH-1:0] cur_mcand;
  logic [_WIDTH-1:0]   cur_mplier;
  logic [2*_WIDTH-1:0] partial;

  // The load cycle already performs step 0, so a square takes exactly N cycles.
  always_comb begin
    load       = start && !busy_q;
    cur_acc    = load ? '0 : acc_q;
    cur_mcand  = load ? {{_WIDTH{1'b0}}, operand} : mcand_q;
    cur_mplier = load ? operand : mplier_q;
    partial    = '0;
    for (int j = 0; j < STEP; j++) begin
      if (cur_mplier[j]) begin
        partial = partial + (cur_mcand << j);
      end
    end
    product = cur_acc + partial;
    done    = busy_q && (step_q == CW'(N - 1));
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      step_q   <= '0;
      busy_q   <= 1'b0;
    end else if (load || busy_q) begin
      acc_q    <= product;
      mcand_q  <= cur_mcand << STEP;
      mplier_q <= cur_mplier >> STEP;
      if (done) begin
        busy_q <= 1'b0;
        step_q <= '0;
      end else begin
        busy_q <= 1'b1;
        step_q <= step_q + CW'(1);
      end
    end
  end

  assign busy = busy_q;
endmodule

// File: rtl/vec_length.sv
// Euclidean length of a Q16.16 3-vector: sum of squares, then a start/ready request to a shared sqrt unit.
// VEC_LENGTH_SAT_EN: saturate the sum of squares and report ovf; otherwise wrap into 31 bits, ovf tied low.
module vec_length
  import definitions_pack::*;
  import math_pack::*;
#(
  parameter int STEP = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  vec_length_if.slave bus
);
  vl_state_t state;
  vl_state_t next_state;

  fixed                x_q;
  fixed                y_q;
  fixed                z_q;
  logic [_WIDTH-1:0]   acc_q;
  logic [_WIDTH-1:0]   acc_next;
  logic [_WIDTH:0]     sum;

  logic                in_ready_q;
  logic                out_valid_q;
  logic                sqrt_start_q;
  logic [_WIDTH-1:0]   sqrt_a_q;
  fixed                len_q;

  logic                sq_active;
  logic                sq_start;
  logic                sq_busy;
  logic                sq_done;
  logic [_WIDTH-1:0]   sq_operand;
  logic [2*_WIDTH-1:0] sq_product;

  fx_sq_iter #(.STEP(STEP)) u_sq (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (sq_start),
    .operand (sq_operand),
    .busy    (sq_busy),
    .done    (sq_done),
    .product (sq_product)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // SQRT_REQ waits for ready to drop so a leftover ready from the last job is never taken as an answer.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:      if (bus.in_valid)    next_state = SQ_X;
      SQ_X:      if (sq_done)         next_state = SQ_Y;
      SQ_Y:      if (sq_done)         next_state = SQ_Z;
      SQ_Z:      if (sq_done)         next_state = SQRT_REQ;
      SQRT_REQ:  if (!bus.sqrt_ready) next_state = SQRT_WAIT;
      SQRT_WAIT: if (bus.sqrt_ready)  next_state = DONE;
      DONE:      if (bus.out_ready)   next_state = IDLE;
      default:                        next_state = IDLE;
    endcase
  end

  always_comb begin
    sq_operand = '0;
    case (state)
      SQ_X:    sq_operand = magnitude(x_q);
      SQ_Y:    sq_operand = magnitude(y_q);
      SQ_Z:    sq_operand = magnitude(z_q);
      default: sq_operand = '0;
    endcase
    sq_active = (state == SQ_X) || (state == SQ_Y) || (state == SQ_Z);
    sq_start  = sq_active && !sq_busy;
  end

`ifdef VEC_LENGTH_SAT_EN
  logic ovf_q;
  logic ovf_step;
  logic unused_frac;

  assign unused_frac = ^sq_product[FB-1:0];

  always_comb begin
    sum      = {1'b0, acc_q} + {1'b0, sq_product[_WIDTH+FB-1:FB]};
    ovf_step = (|sq_product[2*_WIDTH-1:_WIDTH+FB-1]) || (|sum[_WIDTH:_WIDTH-1]);
    acc_next = ovf_step ? SAT_LIMIT : sum[_WIDTH-1:0];
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else if (state == IDLE && bus.in_valid) begin
      ovf_q <= 1'b0;
    end else if (sq_done) begin
      ovf_q <= ovf_q | ovf_step;
    end
  end

  assign bus.ovf = ovf_q;
`else
  logic unused_bits;

  assign unused_bits = ^{sq_product[2*_WIDTH-1:_WIDTH+FB], sq_product[FB-1:0], sum[_WIDTH:_WIDTH-1]};

  // Dropping bit 31 wraps modulo 2^31 and keeps the sqrt operand non-negative.
  always_comb begin
    sum      = {1'b0, acc_q} + {1'b0, sq_product[_WIDTH+FB-1:FB]};
    acc_next = {1'b0, sum[_WIDTH-2:0]};
  end

  assign bus.ovf = 1'b0;
`endif

  // Handshake outputs follow the state being entered, so each one is a plain register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      x_q          <= '0;
      y_q          <= '0;
      z_q          <= '0;
      acc_q        <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      sqrt_start_q <= 1'b0;
      sqrt_a_q     <= '0;
      len_q        <= '0;
    end else begin
      in_ready_q   <= (next_state == IDLE);
      out_valid_q  <= (next_state == DONE);
      sqrt_start_q <= (next_state == SQRT_REQ) || (next_state == SQRT_WAIT);
      if (state == IDLE && bus.in_valid) begin
        x_q   <= bus.x;
        y_q   <= bus.y;
        z_q   <= bus.z;
        acc_q <= '0;
      end
      if (sq_done) begin
        acc_q <= acc_next;
      end
      if (state == SQ_Z && sq_done) begin
        sqrt_a_q <= acc_next;
      end
      if (state == SQRT_WAIT && bus.sqrt_ready) begin
        len_q <= bus.sqrt_b;
      end
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.sqrt_start = sqrt_start_q;
  assign bus.sqrt_a     = sqrt_a_q;
  assign bus.len        = len_q;
endmodule

// File: tb/tb_vec_length.sv
// Directed bench for vec_length (STEP=1) with a behavioural square-root responder.
// Expectations for the overflow case follow VEC_LENGTH_SAT_EN.
module tb_vec_length;
  import definitions_pack::*;
  import math_pack::*;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  vec_length_if bus ();

  vec_length #(.STEP(1)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

`ifdef VEC_LENGTH_SAT_EN
  localparam logic [31:0] OVF_SQRT_A = 32'h7FFF_FFFF;
  localparam logic [31:0] OVF_FLAG   = 32'd1;
`else
  localparam logic [31:0] OVF_SQRT_A = 32'h0003_0000;
  localparam logic [31:0] OVF_FLAG   = 32'd0;
`endif

  int          assertions = 0;
  int          failures = 0;
  logic [31:0] rsp_value = '0;
  int          rsp_delay = 5;
  bit          stale_mode = 1'b0;
  logic        resp_prev = 1'b0;

  logic [63:0] seq_log = '0;
  vl_state_t   mon_state = IDLE;
  logic        mon_start = 1'b0;
  bit          start_seen = 1'b0;
  int          low_run = 0;
  int          min_gap = 1000;

  // Responder: drops ready after seeing the start edge, answers rsp_delay cycles later.
  initial begin
    bus.sqrt_ready = 1'b1;
    bus.sqrt_b = '0;
    forever begin
      @(negedge clock);
      if (bus.sqrt_start && !resp_prev) begin
        if (stale_mode) begin
          bus.sqrt_b = 32'hDEAD_BEEF;
          repeat (3) @(negedge clock);
        end
        bus.sqrt_ready = 1'b0;
        repeat (rsp_delay) @(negedge clock);
        bus.sqrt_b = rsp_value;
        bus.sqrt_ready = 1'b1;
      end
      resp_prev = bus.sqrt_start;
    end
  end

  // State trace as one nibble per change, plus the shortest low gap of sqrt_start between requests.
  initial begin
    forever begin
      @(negedge clock);
      if (dut.state != mon_state) begin
        seq_log = {seq_log[59:0], 1'b0, dut.state};
        mon_state = dut.state;
      end
      if (bus.sqrt_start && !mon_start) begin
        if (start_seen && low_run < min_gap) min_gap = low_run;
        start_seen = 1'b1;
      end
      low_run = bus.sqrt_start ? 0 : low_run + 1;
      mon_start = bus.sqrt_start;
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: observed no end of test, expected completion before 300000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertions++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input fixed vx, input fixed vy, input fixed vz,
                               input logic [31:0] rsp, input int dly, input bit stale);
    bus.x = vx;
    bus.y = vy;
    bus.z = vz;
    rsp_value = rsp;
    rsp_delay = dly;
    stale_mode = stale;
    bus.in_valid = 1'b1;
  endtask

  task automatic waitAccept(input string tag);
    int n = 0;
    while (!bus.in_ready && n < 300) begin
      @(posedge clock); #1;
      n++;
    end
    checkOutput({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clock); #1;
  endtask

  task automatic waitStart(input string tag, input logic [31:0] exp_a);
    int n = 0;
    while (!bus.sqrt_start && n < 400) begin
      @(posedge clock); #1;
      n++;
    end
    checkOutput({tag, "_start_latency"}, 32'(n), 32'd96);
    checkOutput({tag, "_sqrt_a"}, bus.sqrt_a, exp_a);
  endtask

  task automatic waitResult(input string tag, input logic [31:0] exp_len,
                            input logic [31:0] exp_ovf, input int exp_lat);
    int n = 0;
    while (!bus.out_valid && n < 400) begin
      @(posedge clock); #1;
      n++;
    end
    checkOutput({tag, "_result_latency"}, 32'(n), 32'(exp_lat));
    checkOutput({tag, "_len"}, bus.len, exp_len);
    checkOutput({tag, "_ovf"}, 32'(bus.ovf), exp_ovf);
    checkOutput({tag, "_busy_in_ready"}, 32'(bus.in_ready), 32'd0);
  endtask

  task automatic finishOp(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clock); #1;
    checkOutput({tag, "_out_valid_clear"}, 32'(bus.out_valid), 32'd0);
    checkOutput({tag, "_idle_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;
    @(negedge clock); #1;
    checkOutput({tag, "_states"}, {4'd0, seq_log[27:0]}, 32'h0123_4560);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.x = '0;
    bus.y = '0;
    bus.z = '0;
    bus.out_ready = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_sqrt_start", 32'(bus.sqrt_start), 32'd0);
    checkOutput("reset_len", bus.len, 32'd0);
    checkOutput("reset_ovf", 32'(bus.ovf), 32'd0);
    checkOutput("reset_sqrt_a", bus.sqrt_a, 32'd0);
    reset_n = 1'b1;

    applyStimulus(32'h0003_0000, 32'h0004_0000, 32'h0000_0000, 32'h0005_0000, 5, 1'b0);
    waitAccept("tri");
    bus.in_valid = 1'b0;
    waitStart("tri", 32'h0019_0000);
    waitResult("tri", 32'h0005_0000, 32'd0, 6);
    finishOp("tri");

    applyStimulus(32'hFFFE_8000, 32'h0000_0000, 32'h0000_0000, 32'h0001_8000, 3, 1'b0);
    waitAccept("neg");
    bus.in_valid = 1'b0;
    waitStart("neg", 32'h0002_4000);
    waitResult("neg", 32'h0001_8000, 32'd0, 4);
    finishOp("neg");

    applyStimulus(32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 32'h0000_ABCD, 2, 1'b0);
    waitAccept("ovf");
    bus.in_valid = 1'b0;
    waitStart("ovf", OVF_SQRT_A);
    waitResult("ovf", 32'h0000_ABCD, OVF_FLAG, 3);
    finishOp("ovf");

    applyStimulus(32'h0003_0000, 32'h0004_0000, 32'h0000_0000, 32'h0005_0000, 20, 1'b1);
    waitAccept("stale");
    bus.in_valid = 1'b0;
    waitStart("stale", 32'h0019_0000);
    waitResult("stale", 32'h0005_0000, 32'd0, 24);
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      checkOutput("stale_hold_len", bus.len, 32'h0005_0000);
      checkOutput("stale_hold_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("stale_hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    finishOp("stale");

    applyStimulus(32'h0001_0000, 32'h0002_0000, 32'h0002_0000, 32'h0003_0000, 5, 1'b0);
    waitAccept("rst");
    bus.in_valid = 1'b0;
    repeat (40) @(posedge clock);
    #1;
    reset_n = 1'b0;
    @(posedge clock); #1;
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_sqrt_start", 32'(bus.sqrt_start), 32'd0);
    checkOutput("rst_len", bus.len, 32'd0);
    reset_n = 1'b1;
    @(negedge clock); #1;
    checkOutput("rst_states", {20'd0, seq_log[11:0]}, 32'h0000_0120);

    applyStimulus(32'h0003_0000, 32'h0004_0000, 32'h0000_0000, 32'h0005_0000, 5, 1'b0);
    waitAccept("post_rst");
    bus.in_valid = 1'b0;
    waitStart("post_rst", 32'h0019_0000);
    waitResult("post_rst", 32'h0005_0000, 32'd0, 6);
    finishOp("post_rst");

    applyStimulus(32'h0001_0000, 32'h0002_0000, 32'h0002_0000, 32'h0003_0000, 4, 1'b0);
    bus.out_ready = 1'b1;
    waitAccept("b2b1");
    waitStart("b2b1", 32'h0009_0000);
    waitResult("b2b1", 32'h0003_0000, 32'd0, 5);
    bus.x = '0;
    bus.y = '0;
    bus.z = '0;
    rsp_value = '0;
    waitAccept("b2b2");
    bus.in_valid = 1'b0;
    waitStart("b2b2", 32'h0000_0000);
    waitResult("b2b2", 32'h0000_0000, 32'd0, 5);
    finishOp("b2b2");
    checkOutput("start_low_gap_ok", 32'(min_gap >= 2), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end
endmodule

// File: doc/vec_length.md
# vec_length

Computes the Euclidean length √(x²+y²+z²) of a fixed-point 3-vector for the coprocessor datapath.
- Squares and sums the three components with an iterative shift-add multiplier.
- Acts as the initiator of the start/ready square-root handshake: drives operand and start to the shared square-root responder, then returns its result.
- Downstream users are normalisation and lighting stages.

## Interface
Parameters:
- STEP, 1: multiplier bits retired per cycle; legal values are 1, 2 and 4.

Ports (all widths from `definitions_pack`: `fixed` is `_WIDTH`=32 bits, `BI`=16 integer bits, FB=`_WIDTH`-`BI` fractional bits):
- clock  in  1  single clock; every output is registered on its rising edge
- reset_n  in  1  reset is synchronous and active-low
- in_valid  in  1  request strobe
- in_ready  out  1  high only in IDLE; reset 1
- x, y, z  in  fixed  signed components; sampled when in_valid & in_ready
- out_valid  out  1  result valid; reset 0
- out_ready  in  1  consumer accept
- len  out  fixed  length result; reset 0
- ovf  out  1  the sum of squares saturated; reset 0
- sqrt_start  out  1  level request to the square-root responder; reset 0
- sqrt_a  out  fixed  non-negative operand for the responder; reset 0
- sqrt_b  in  fixed  responder result
- sqrt_ready  in  1  responder done flag

## Operation
- FSM states: IDLE → SQ_X → SQ_Y → SQ_Z → SQRT_REQ → SQRT_WAIT → DONE → IDLE.
- IDLE: a handshake latches x, y, z, clears the accumulator and clears ovf, then goes to SQ_X.
- SQ_*:
  - Take the magnitude |c| as an unsigned `_WIDTH`-bit value; |−2^31| = 2^31 is representable.
  - Run shift-add squaring for `_WIDTH`/STEP cycles.
  - Product is the 2·`_WIDTH` unsigned value; the scaled square is product[`_WIDTH`+FB−1 : FB].
  - Add the scaled square to the accumulator.
  - Any set bit above bit `_WIDTH`−2, in the product or in the sum, is an overflow.
- SQRT_REQ:
  - sqrt_a = accumulator; sqrt_start = 1.
  - Stay until sqrt_ready is sampled 0. The responder clears ready only after it sees the start edge, so a stale ready=1 from the previous operation is ignored.
- SQRT_WAIT: sqrt_start stays 1; wait for sqrt_ready == 1, then capture len = sqrt_b.
- DONE:
  - sqrt_start = 0; out_valid = 1.
  - len and ovf are held stable until out_ready, then go to IDLE.
  - sqrt_start is therefore low for at least 2 cycles between requests, which guarantees a fresh rising edge at the responder.
- Zero vector: sqrt_a = 0. The block waits on the handshake normally; no bypass.
- reset_n low in any state: next edge enters IDLE with all outputs at their reset values. A responder still computing is abandoned; the next start edge restarts it.

## Timing
- Accept edge E0. Squaring occupies cycles E0+1 … E0+3·(`_WIDTH`/STEP); accumulation happens on the last cycle of each square.
- sqrt_start rises the cycle after SQ_Z completes.
- len and out_valid are registered one edge after sqrt_ready is seen high in SQRT_WAIT.
- Total latency (STEP=1) = 96 + 1 + T_sqrt + 1 cycles, where T_sqrt is the responder's start-to-ready time including its clear.
- in_valid outside IDLE is ignored. Simultaneous out_ready & in_valid in DONE: the new request is accepted at the earliest one cycle later, from IDLE.

## Configuration
- VEC_LENGTH_SAT_EN defined: on overflow the accumulator saturates to 0x7FFF_FFFF and ovf = 1.
- VEC_LENGTH_SAT_EN undefined:
  - Squares and sum wrap modulo 2^(`_WIDTH`−1); the MSB is forced to 0 so sqrt_a is always non-negative.
  - ovf is tied to 0.

## Structure
- `definitions_pack`: `fixed`, `_WIDTH`, `BI`.
- `math_pack`: FB constant, the saturation limit constant, and the FSM state enum `vl_state_t`.
- Sub-module `fx_sq_iter`: iterative unsigned shift-add squarer with ports start/busy/done, STEP-parameterised, instantiated once and reused for x, y, z.

## Test plan
Values are Q16.16 with STEP=1; every case checks the FSM state sequence.
- **3-4-0 triangle:** x=0x0003_0000, y=0x0004_0000, z=0 → sqrt_a=0x0019_0000. Responder returns 0x0005_0000 → len=0x0005_0000, ovf=0.
- **Negative component:** x=0xFFFE_8000 (−1.5), y=z=0 → sqrt_a=0x0002_4000 (2.25).
- **Overflow:** x=y=z=0x7FFF_0000.
  - With VEC_LENGTH_SAT_EN: sqrt_a=0x7FFF_FFFF, ovf=1.
  - Without it: ovf=0, sqrt_a MSB=0.
- **Stale ready:** responder holds sqrt_ready=1 for 3 cycles after sqrt_start rises, then 0 for 20 cycles, then 1 → len is captured only after the 0→1 transition. out_ready held low 5 cycles → len stable, in_ready=0.
- **Reset mid-operation:** reset_n low during SQ_Y → next edge in_ready=1 and out_valid=0, sqrt_start=0, len=0. A following 3-4-0 request returns 0x0005_0000.
- **Back-to-back:** two requests with in_valid held high → sqrt_start low for ≥2 cycles between them; both results correct.
